// File: rtl/muldiv_pkg.sv
// Shared opcode encoding, FSM state encoding and constants for the
// multi-cycle multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULW = 3'd1,
        ST_DIVI = 3'd2,
        ST_FIX  = 3'd3,
        ST_SPEC = 3'd4,
        ST_FIN  = 3'd5
    } state_e;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    function automatic logic is_muldiv_op(input logic [4:0] sel);
        return (sel >= OP_MUL) && (sel <= OP_REMU);
    endfunction

    function automatic logic is_mul_op(input logic [4:0] sel);
        return (sel >= OP_MUL) && (sel <= OP_MULHU);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] sel);
        return (sel == OP_REM) || (sel == OP_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [4:0] sel);
        return (sel == OP_DIV) || (sel == OP_REM);
    endfunction

    // MUL keeps the low word; every MULH* variant returns the high word.
    function automatic logic [31:0] mul_pick(input logic [4:0] op, input logic [63:0] prod);
        if (op == OP_MUL) begin
            return prod[31:0];
        end else begin
            return prod[63:32];
        end
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_core.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits, and shift the resulting quotient bit in.
module div_core (
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);

    logic        fits_s;
    logic [32:0] trial_s;
    logic [32:0] sub_s;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        trial_s = {rem_i[31:0], quo_i[31]};
        fits_s  = ({rem_i, quo_i[31]} >= {2'b00, dvs_i});
        sub_s   = trial_s - {1'b0, dvs_i};
        if (fits_s) begin
            rem_o = sub_s;
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = trial_s;
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// M-extension sequencer: fixed-latency multiply, 32-step restoring divide,
// pipeline STALL while busy and a registered RESULT with a one-cycle DONE.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int XLEN    = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic [4:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            KILL,
    output logic [XLEN-1:0] RESULT,
    output logic            DONE,
    output logic            BUSY,
    output logic            STALL
);

    state_e      state_q;
    logic [4:0]  op_q;
    logic [4:0]  cnt_q;
    logic [63:0] prod_q;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        qneg_q;
    logic        rneg_q;
    logic [31:0] result_q;
    logic        done_q;
    logic        busy_q;

    logic        accept_s;
    logic        mul_s;
    logic        div_sgn_s;
    logic        d1_neg_s;
    logic        d2_neg_s;
    logic        spec_s;
    logic [31:0] d1_mag_s;
    logic [31:0] d2_mag_s;
    logic [31:0] spec_val_s;
    logic [31:0] fix_val_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic [32:0] rem_d;
    logic [31:0] quo_d;

    div_core u_div_core (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    // Accept decode plus operand preparation from the live inputs.
    always_comb begin
        accept_s  = START && is_muldiv_op(SELECT) &&
                    ((state_q == ST_IDLE) || (state_q == ST_FIN)) && !KILL;
        mul_s     = is_mul_op(SELECT);
        // Sign-extended operands make the low 64 bits of the product exact for all variants.
        mul_a_s   = {{32{((SELECT == OP_MULH) || (SELECT == OP_MULHSU)) && DATA1[31]}}, DATA1};
        mul_b_s   = {{32{(SELECT == OP_MULH) && DATA2[31]}}, DATA2};
        prod_s    = mul_a_s * mul_b_s;
        div_sgn_s = is_signed_div(SELECT);
        d1_neg_s  = div_sgn_s && DATA1[31];
        d2_neg_s  = div_sgn_s && DATA2[31];
        d1_mag_s  = d1_neg_s ? (32'd0 - DATA1) : DATA1;
        d2_mag_s  = d2_neg_s ? (32'd0 - DATA2) : DATA2;
        if (DATA2 == 32'd0) begin
            spec_s     = 1'b1;
            spec_val_s = is_rem_op(SELECT) ? DATA1 : ALL_ONES;
        end else if (div_sgn_s && (DATA1 == INT_MIN) && (DATA2 == ALL_ONES)) begin
            spec_s     = 1'b1;
            spec_val_s = is_rem_op(SELECT) ? 32'd0 : INT_MIN;
        end else begin
            spec_s     = 1'b0;
            spec_val_s = 32'd0;
        end
    end

    // Sign correction of the unsigned quotient/remainder left by the iterations.
    always_comb begin
        if (is_rem_op(op_q)) begin
            fix_val_s = rneg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
        end else begin
            fix_val_s = qneg_q ? (32'd0 - quo_q) : quo_q;
        end
    end

    // Sequencer FSM with all operand, counter and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            op_q     <= 5'd0;
            cnt_q    <= 5'd0;
            prod_q   <= 64'd0;
            rem_q    <= 33'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (KILL) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_FIN: begin
                        if (accept_s) begin
                            op_q <= SELECT;
                            if (mul_s) begin
                                prod_q <= prod_s;
                                if (MUL_LAT == 1) begin
                                    state_q  <= ST_FIN;
                                    result_q <= mul_pick(SELECT, prod_s);
                                    done_q   <= 1'b1;
                                    busy_q   <= 1'b0;
                                end else begin
                                    state_q <= ST_MULW;
                                    cnt_q   <= 5'(MUL_LAT - 2);
                                    busy_q  <= 1'b1;
                                end
                            end else if (spec_s) begin
                                state_q <= ST_SPEC;
                                quo_q   <= spec_val_s;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= ST_DIVI;
                                rem_q   <= 33'd0;
                                quo_q   <= d1_mag_s;
                                dvs_q   <= d2_mag_s;
                                qneg_q  <= d1_neg_s ^ d2_neg_s;
                                rneg_q  <= d1_neg_s;
                                cnt_q   <= 5'(DIV_ITERS - 1);
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_MULW: begin
                        if (cnt_q == 5'd0) begin
                            state_q  <= ST_FIN;
                            result_q <= mul_pick(op_q, prod_q);
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                    ST_DIVI: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        if (cnt_q == 5'd0) begin
                            state_q <= ST_FIX;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                    ST_FIX: begin
                        state_q  <= ST_FIN;
                        result_q <= fix_val_s;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                    ST_SPEC: begin
                        state_q  <= ST_FIN;
                        result_q <= quo_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign RESULT = result_q;
    assign DONE   = done_q;
    assign BUSY   = busy_q;
    assign STALL  = busy_q | accept_s;

endmodule
